peripheral_msi_arbiter_ahb3: RTL and testbench

Per-slave-port arbiter for the AHB3 MSI crossbar; one instance per slave port. Selects which master owns the slave each address phase. Selection is by 3-bit master priority, then round-robin among equal-priority requesters. Grants change only on legal AHB boundaries: slave HREADY high, and the current owner either signals can_switch or has dropped its request. HMASTLOCK sequences are honoured.

---
 rtl/peripheral_msi_arbiter_ahb3_pkg.sv | 22 ++
 rtl/peripheral_msi_arbiter_ahb3_if.sv | 26 ++
 rtl/peripheral_msi_arbiter_ahb3_rr_pick.sv | 40 ++++
 rtl/peripheral_msi_arbiter_ahb3.sv | 105 ++++++++++
 tb/tb_peripheral_msi_arbiter_ahb3.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/peripheral_msi_arbiter_ahb3_pkg.sv
// Shared types and constants for the AHB3 MSI crossbar slave-port arbiter.
package peripheral_msi_pkg_ahb3;

    localparam int PRIO_W = 3;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_OWNED  = 2'd1,
        ARB_LOCKED = 2'd2
    } arb_state_e;

    // Index width for n masters, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/peripheral_msi_arbiter_ahb3_if.sv
// Request/grant bundle between the masters' request decode and one slave-port arbiter.
interface peripheral_msi_arbiter_ahb3_if
    import peripheral_msi_pkg_ahb3::*;
#(
    parameter int MASTERS = 5,
    parameter int MIDX    = idx_w(MASTERS)
);
    logic [MASTERS-1:0]        mst_req;
    logic [MASTERS*PRIO_W-1:0] mst_priority;
    logic [MASTERS-1:0]        mst_canswitch;
    logic [MASTERS-1:0]        mst_lock;
    logic                      slv_HREADY;
    logic [MASTERS-1:0]        granted_master;
    logic [MIDX-1:0]           granted_idx;
    logic                      grant_valid;

    modport master (
        output mst_req, mst_priority, mst_canswitch, mst_lock, slv_HREADY,
        input  granted_master, granted_idx, grant_valid
    );

    modport slave (
        input  mst_req, mst_priority, mst_canswitch, mst_lock, slv_HREADY,
        output granted_master, granted_idx, grant_valid
    );
endinterface

// File: rtl/peripheral_msi_arbiter_ahb3_rr_pick.sv
// Round-robin picker: first set bit of cand strictly after ptr, wrapping to 0.
module peripheral_msi_rr_pick_ahb3
    import peripheral_msi_pkg_ahb3::*;
#(
    parameter int MASTERS = 5,
    parameter int MIDX    = idx_w(MASTERS)
) (
    input  logic [MASTERS-1:0] cand,
    input  logic [MIDX-1:0]    ptr,
    output logic [MASTERS-1:0] win,
    output logic [MIDX-1:0]    win_idx
);
    logic [2*MASTERS-1:0] dbl;
    logic [2*MASTERS-1:0] rot;
    logic                 found;
    int                   off;
    int                   sum;

    // Doubling the vector lets a plain right shift act as a rotate.
    always_comb begin
        dbl   = {cand, cand};
        rot   = dbl >> (int'(ptr) + 1);
        found = 1'b0;
        off   = 0;
        for (int j = 0; j < MASTERS; j++) begin
            if (!found && rot[j]) begin
                found = 1'b1;
                off   = j;
            end
        end
        sum = int'(ptr) + 1 + off;
        if (sum >= MASTERS) sum = sum - MASTERS;
        win = '0;
        for (int i = 0; i < MASTERS; i++) begin
            win[i] = found && (sum == i);
        end
        win_idx = found ? MIDX'(sum) : '0;
    end

endmodule

// File: rtl/peripheral_msi_arbiter_ahb3.sv
// Per-slave-port arbiter: priority first, round-robin among ties, AHB-boundary and lock aware.
//  state      | meaning
//  ST_IDLE    | no owner, grant all-zero
//  ST_OWNED   | owner holds slave, unlocked
//  ST_LOCKED  | owner holds slave under HMASTLOCK
module peripheral_msi_arbiter_ahb3
    import peripheral_msi_pkg_ahb3::*;
#(
    parameter int MASTERS = 5,
    parameter int MIDX    = idx_w(MASTERS)
) (
    input logic                          HCLK,
    input logic                          HRESETn,
    peripheral_msi_arbiter_ahb3_if.slave bus
);
    localparam logic [1:0]      ST_IDLE   = ARB_IDLE;
    localparam logic [1:0]      ST_OWNED  = ARB_OWNED;
    localparam logic [1:0]      ST_LOCKED = ARB_LOCKED;
    localparam logic [MIDX-1:0] PTR_RST   = MIDX'(MASTERS - 1);

    logic [1:0]         state;
    logic [MASTERS-1:0] grant_q;
    logic [MIDX-1:0]    idx_q;
    logic [MIDX-1:0]    ptr_q;
    logic               valid_q;

    logic [PRIO_W-1:0]  maxp;
    logic [MASTERS-1:0] cand;
    logic [MASTERS-1:0] win;
    logic [MIDX-1:0]    win_idx;
    logic               owner_req;
    logic               owner_cs;
    logic               owner_lock;
    logic               win_lock;
    logic               arb_edge;

    always_comb begin
        maxp = '0;
        for (int i = 0; i < MASTERS; i++) begin
            if (bus.mst_req[i] && (bus.mst_priority[i*PRIO_W +: PRIO_W] > maxp))
                maxp = bus.mst_priority[i*PRIO_W +: PRIO_W];
        end
        cand = '0;
        for (int i = 0; i < MASTERS; i++) begin
            cand[i] = bus.mst_req[i] && (bus.mst_priority[i*PRIO_W +: PRIO_W] == maxp);
        end
    end

    peripheral_msi_rr_pick_ahb3 #(
        .MASTERS (MASTERS),
        .MIDX    (MIDX)
    ) u_pick (
        .cand    (cand),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx)
    );

    // The grant register is one-hot, so masking selects the owner's controls.
    assign owner_req  = |(grant_q & bus.mst_req);
    assign owner_cs   = |(grant_q & bus.mst_canswitch);
    assign owner_lock = |(grant_q & bus.mst_lock);
    assign win_lock   = |(win & bus.mst_lock);

    always_comb begin
        arb_edge = 1'b0;
        if (state == ST_IDLE)
            arb_edge = 1'b1;
        else if (state == ST_OWNED)
            arb_edge = owner_cs || !owner_req;
        else if (state == ST_LOCKED)
            arb_edge = !owner_lock || !owner_req;
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state   <= ST_IDLE;
            grant_q <= '0;
            idx_q   <= '0;
            ptr_q   <= PTR_RST;
            valid_q <= 1'b0;
        end else if (bus.slv_HREADY) begin
            if (arb_edge) begin
                if (cand == '0) begin
                    state   <= ST_IDLE;
                    grant_q <= '0;
                    valid_q <= 1'b0;
                end else begin
                    state   <= win_lock ? ST_LOCKED : ST_OWNED;
                    grant_q <= win;
                    idx_q   <= win_idx;
                    ptr_q   <= win_idx;
                    valid_q <= 1'b1;
                end
            end else if (state == ST_OWNED && owner_lock) begin
                state <= ST_LOCKED;
            end
        end
    end

    assign bus.granted_master = grant_q;
    assign bus.granted_idx    = idx_q;
    assign bus.grant_valid    = valid_q;

endmodule

// File: tb/tb_peripheral_msi_arbiter_ahb3.sv
// Directed bench for the slave-port arbiter with a cycle-level reference model.
module tb_peripheral_msi_arbiter_ahb3;
    localparam int M = 5;

    logic HCLK    = 1'b0;
    logic HRESETn = 1'b0;

    peripheral_msi_arbiter_ahb3_if #(.MASTERS(M)) bus();

    peripheral_msi_arbiter_ahb3 #(.MASTERS(M)) dut (
        .HCLK    (HCLK),
        .HRESETn (HRESETn),
        .bus     (bus)
    );

    always #5 HCLK = ~HCLK;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string name, input int got, input int exp);
        n_total++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    endtask

    // Reference model: owner as an integer (-1 = none), plus lock flag and tie pointer.
    int m_owner  = -1;
    bit m_locked = 1'b0;
    int m_ptr    = M - 1;
    int m_idx    = 0;

    function automatic int prio_of(input logic [3*M-1:0] pr, input int c);
        return int'(pr[3*c +: 3]);
    endfunction

    function automatic int pick_winner(input logic [M-1:0] req, input logic [3*M-1:0] pr,
                                       input int ptr);
        int maxp = -1;
        int w    = -1;
        for (int c = 0; c < M; c++)
            if (req[c] && prio_of(pr, c) > maxp) maxp = prio_of(pr, c);
        for (int k = 1; k <= M; k++) begin
            int c = (ptr + k) % M;
            if (w < 0 && req[c] && prio_of(pr, c) == maxp) w = c;
        end
        return w;
    endfunction

    always @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            m_owner  = -1;
            m_locked = 1'b0;
            m_ptr    = M - 1;
            m_idx    = 0;
        end else if (bus.slv_HREADY) begin
            bit boundary;
            int w;
            if (m_owner < 0)                  boundary = 1'b1;
            else if (!bus.mst_req[m_owner])   boundary = 1'b1;
            else if (m_locked)                boundary = !bus.mst_lock[m_owner];
            else                              boundary = bus.mst_canswitch[m_owner];
            if (boundary) begin
                w = pick_winner(bus.mst_req, bus.mst_priority, m_ptr);
                if (w < 0) begin
                    m_owner  = -1;
                    m_locked = 1'b0;
                end else begin
                    m_owner  = w;
                    m_ptr    = w;
                    m_idx    = w;
                    m_locked = bus.mst_lock[w];
                end
            end else if (!m_locked && bus.mst_lock[m_owner]) begin
                m_locked = 1'b1;
            end
        end
    end

    always @(negedge HCLK) begin
        int exp_gm;
        exp_gm = (m_owner < 0) ? 0 : (1 << m_owner);
        check("model_granted_master", int'(bus.granted_master), exp_gm);
        check("model_granted_idx",    int'(bus.granted_idx),    m_idx);
        check("model_grant_valid",    int'(bus.grant_valid),    (m_owner >= 0) ? 1 : 0);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge HCLK);
            #1;
        end
    endtask

    task automatic drive(input logic [M-1:0] req, input logic [3*M-1:0] pr,
                         input logic [M-1:0] cs, input logic [M-1:0] lk, input logic rdy);
        bus.mst_req       = req;
        bus.mst_priority  = pr;
        bus.mst_canswitch = cs;
        bus.mst_lock      = lk;
        bus.slv_HREADY    = rdy;
    endtask

    task automatic expect_grant(input string name, input int idx);
        check({name, "_idx"},   int'(bus.granted_idx),    idx);
        check({name, "_onehot"}, int'(bus.granted_master), 1 << idx);
        check({name, "_valid"}, int'(bus.grant_valid),    1);
    endtask

    initial begin
        logic [3*M-1:0] pr;
        drive('0, '0, '0, '0, 1'b1);
        tick(2);
        check("reset_gm",    int'(bus.granted_master), 0);
        check("reset_idx",   int'(bus.granted_idx),    0);
        check("reset_valid", int'(bus.grant_valid),    0);

        // single requester right after reset release
        drive(5'b00100, '0, '0, '0, 1'b1);
        HRESETn = 1'b1;
        tick(1);
        expect_grant("first_grant", 2);

        // equal priority round-robin from a fresh pointer
        HRESETn = 1'b0;
        drive(5'b11111, {5{3'd3}}, 5'b11111, '0, 1'b1);
        tick(1);
        HRESETn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            expect_grant("rr_rotate", i % 5);
        end

        // low-priority owner held until its boundary
        HRESETn = 1'b0;
        pr = 15'd1 << 3;
        drive(5'b00010, pr, '0, '0, 1'b1);
        tick(1);
        HRESETn = 1'b1;
        tick(1);
        expect_grant("m1_owns", 1);
        pr = (15'd1 << 3) | (15'd6 << 9);
        drive(5'b01010, pr, '0, '0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            expect_grant("m1_held", 1);
        end
        drive(5'b01010, pr, 5'b00010, '0, 1'b1);
        tick(1);
        expect_grant("m3_after_switch", 3);

        // locked owner blocks a higher-priority master
        HRESETn = 1'b0;
        drive(5'b00001, '0, 5'b00001, 5'b00001, 1'b1);
        tick(1);
        HRESETn = 1'b1;
        tick(1);
        expect_grant("m0_lock", 0);
        pr = 15'd7 << 6;
        drive(5'b00101, pr, 5'b00001, 5'b00001, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            expect_grant("m0_lock_held", 0);
        end
        drive(5'b00101, pr, 5'b00001, '0, 1'b1);
        tick(1);
        expect_grant("m2_after_unlock", 2);

        // HREADY low freezes everything even though the owner dropped
        drive(5'b10000, pr, 5'b00001, '0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            tick(1);
            expect_grant("hready_frozen", 2);
        end
        drive(5'b10000, pr, 5'b00001, '0, 1'b1);
        tick(1);
        expect_grant("m4_after_hready", 4);

        // no requesters: idle, index holds last owner
        drive('0, pr, 5'b00001, '0, 1'b1);
        tick(1);
        check("idle_gm",    int'(bus.granted_master), 0);
        check("idle_valid", int'(bus.grant_valid),    0);
        check("idle_idx",   int'(bus.granted_idx),    4);

        // lock M4, then reset mid-cycle
        drive(5'b10000, '0, 5'b11111, 5'b10000, 1'b1);
        tick(1);
        expect_grant("m4_lock", 4);
        drive(5'b10001, '0, 5'b11111, 5'b10000, 1'b1);
        tick(1);
        expect_grant("m4_lock_held", 4);
        #2;
        HRESETn = 1'b0;
        #1;
        check("async_rst_gm",    int'(bus.granted_master), 0);
        check("async_rst_idx",   int'(bus.granted_idx),    0);
        check("async_rst_valid", int'(bus.grant_valid),    0);
        drive(5'b00011, '0, '0, '0, 1'b1);
        tick(1);
        HRESETn = 1'b1;
        tick(1);
        expect_grant("post_reset_m0", 0);

        tick(2);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
